// File: rtl/rf_wb_arbiter_pkg.sv
// Shared register-file widths and the writeback request type used by the
// write-port arbiter and its B-side buffer.
package rf_wb_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rw;
    logic [DATA_W-1:0]     data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback requests. Every slot and its valid flag are
// exposed so the arbiter can build the pending-register scoreboard.
module wb_fifo
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  wb_req_t              push_req,
  input  logic                 pop,
  output wb_req_t              head,
  output logic                 full,
  output logic                 empty,
  output logic [DEPTH-1:0]     entry_valid,
  output wb_req_t [DEPTH-1:0]  entries
);

  localparam int IDX_W = $clog2(DEPTH);

  wb_req_t          mem_q [DEPTH];
  logic [IDX_W:0]   wr_ptr_q, wr_ptr_d;
  logic [IDX_W:0]   rd_ptr_q, rd_ptr_d;
  logic [IDX_W:0]   count;
  logic             do_push, do_pop;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
                   (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = wr_ptr_q - rd_ptr_q;
  assign head    = mem_q[rd_ptr_q[IDX_W-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[IDX_W-1:0]] <= push_req;
  end

  // A slot is live when its distance from the read index is below the count.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    logic [IDX_W-1:0] offs;
    assign offs            = IDX_W'(gi) - rd_ptr_q[IDX_W-1:0];
    assign entry_valid[gi] = ({1'b0, offs} < count);
    assign entries[gi]     = mem_q[gi];
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: datapath writeback (A) has priority,
// buffered mul/div writebacks (B) are forced through after STARVE_LIMIT losses.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [REG_ADDR_W-1:0] a_rw,
  input  logic [DATA_W-1:0]     a_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [REG_ADDR_W-1:0] b_rw,
  input  logic [DATA_W-1:0]     b_data,
  output logic                  regWr,
  output logic [REG_ADDR_W-1:0] Rw,
  output logic [DATA_W-1:0]     busW,
  output logic [NUM_REGS-1:0]   busy
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  wb_req_t              head;
  wb_req_t [DEPTH-1:0]  entries;
  logic [DEPTH-1:0]     entry_valid;
  logic                 full, empty;
  logic                 force_b, grant_a, grant_b, push;

  logic [SW-1:0]         starve_q, starve_d;
  logic                  regwr_q, regwr_d;
  logic [REG_ADDR_W-1:0] rw_q, rw_d;
  logic [DATA_W-1:0]     busw_q, busw_d;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .push_req    ('{rw: b_rw, data: b_data}),
    .pop         (grant_b),
    .head        (head),
    .full        (full),
    .empty       (empty),
    .entry_valid (entry_valid),
    .entries     (entries)
  );

  assign force_b = !empty && (starve_q == SW'(STARVE_LIMIT));
  assign a_ready = !force_b;
  assign b_ready = !full;
  assign grant_a = a_valid && !force_b;
  assign grant_b = !grant_a && !empty;
  // Writes to register 0 are accepted but never buffered or issued.
  assign push    = b_valid && b_ready && (b_rw != '0);

  always_comb begin
    starve_d = starve_q;
    regwr_d  = 1'b0;
    rw_d     = rw_q;
    busw_d   = busw_q;
    if (empty || grant_b)
      starve_d = '0;
    else if (starve_q != SW'(STARVE_LIMIT))
      starve_d = starve_q + 1'b1;
    if (grant_a && (a_rw != '0)) begin
      regwr_d = 1'b1;
      rw_d    = a_rw;
      busw_d  = a_data;
    end else if (grant_b) begin
      regwr_d = 1'b1;
      rw_d    = head.rw;
      busw_d  = head.data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
      regwr_q  <= 1'b0;
      rw_q     <= '0;
      busw_q   <= '0;
    end else begin
      starve_q <= starve_d;
      regwr_q  <= regwr_d;
      rw_q     <= rw_d;
      busw_q   <= busw_d;
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < DEPTH; i++)
      if (entry_valid[i]) busy[entries[i].rw] = 1'b1;
    busy[0] = 1'b0;
  end

  assign regWr = regwr_q;
  assign Rw    = rw_q;
  assign busW  = busw_q;

endmodule
